bin2gry_ser: RTL
================

# bin2gry_ser

Bit-serial binary-to-Gray encoder with valid/ready handshakes on both sides. It sits directly upstream of the Gray-to-binary decode stage and produces the Gray code words that stage consumes. Conversion walks one bit per clock from MSB to LSB, matching the decoder's serial style. The result is held on a registered output until the downstream stage accepts it.

## Interface
- `WIDTH`, default 4: code width in bits; legal range ≥ 2.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `bin_in`  in  WIDTH: binary word; sampled on input handshake.
- `bin_valid`  in  1: upstream word valid.
- `bin_ready`  out  1: block can accept a word.
- `gry_out`  out  WIDTH: Gray result, registered.
- `gry_valid`  out  1: `gry_out` valid.
- `gry_ready`  in  1: downstream accepts result.
- `busy`  out  1: high in CALC or HOLD.
- `gry_par`  out  1: XOR of all `gry_out` bits. Present only with `B2G_PARITY_EN`.

## Operation
- **FSM states:** IDLE, CALC, HOLD.
- **IDLE:**
  - `bin_ready`=1.
  - When `bin_valid`&`bin_ready`: capture `bin_in` into `bin_q`, set `idx`=WIDTH-1, go to CALC.
- **CALC:**
  - Each cycle: `gry_q[idx]` <= `bin_q[idx]` ^ `bin_q[idx+1]`, using a zero-extended `bin_q[WIDTH]`=0, so MSB is copied.
  - If `idx`==0: load `gry_out`<=final value, set `gry_valid`=1, go to HOLD.
  - Otherwise decrement `idx`.
- **HOLD:**
  - `gry_out` and `gry_valid` stay stable.
  - On `gry_valid`&`gry_ready`: clear `gry_valid`, go to IDLE.
- `bin_ready`=0 in CALC and HOLD. `bin_valid` is ignored there; upstream holds its word per valid/ready rules.
- `gry_out` keeps its last value after handoff until the next conversion completes. It is never cleared except by reset.
- `idx` counter width is $clog2(WIDTH). There is no wrap: exit occurs at 0.
- Illegal state encoding goes to IDLE.

## Timing
- **Reset values:** `bin_ready`=0 while `rst_n` low, then 1 from the first cycle in IDLE. `gry_out`=0, `gry_valid`=0, `busy`=0, `gry_par`=0, FSM=IDLE.
- **Latency:** input handshake at edge T → `gry_valid` high after edge T+WIDTH. For WIDTH=4, valid is seen 4 cycles after acceptance.
- **Throughput:** with `gry_ready` tied high, one word per WIDTH+2 cycles. That is WIDTH CALC cycles, 1 HOLD cycle, and 1 IDLE cycle.
- **Downstream back-pressure:** HOLD persists indefinitely; the output is unchanged.
- **`gry_ready` already high when `gry_valid` rises:** handoff completes on the next edge.
- **Reset mid-CALC or mid-HOLD:** abort immediately. The partial result is discarded and all outputs return to reset values.
- **Repeated identical inputs:** each one is converted and delivered. No change-detection suppression.

## Configuration
- `B2G_PARITY_EN` defined:
  - `gry_par` port exists.
  - It is registered alongside `gry_out` when HOLD is entered, so it is always consistent with `gry_out`.
  - Reset value is 0.
- Undefined: port and logic are absent; all other behaviour is identical.

## Structure
- **Shared package `gray_pkg`:**
  - FSM state typedef (IDLE/CALC/HOLD).
  - Default width constant `GRAY_W`=4, shared with the Gray-to-binary stage.
- **Sub-modules:** none is natural. The per-bit XOR is a single expression, and the FSM, counter and handshake stay in one module.

## Test plan
All scenarios use WIDTH=4.
- Reset release then `bin_in`=4'b0110 with valid and `gry_ready`=1 → `gry_out`=4'b0101, `gry_valid` for 1 cycle, 4 cycles after acceptance.
- `bin_in`=4'b1111 → `gry_out`=4'b1000. Then `bin_in`=4'b0000 → `gry_out`=4'b0000. `bin_ready`=0 throughout each conversion.
- `gry_ready` low for 5 cycles after `gry_valid` → `gry_out` stable, `bin_ready`=0, a new `bin_valid` is not accepted. Release `gry_ready` → IDLE on the next edge.
- Assert `rst_n` low on the 2nd CALC cycle of `bin_in`=4'b1001 → all outputs 0, IDLE. Next conversion of 4'b1001 → 4'b1101.
- With `B2G_PARITY_EN`: `bin_in`=4'b1011 → `gry_out`=4'b1110, `gry_par`=1. `bin_in`=4'b0110 → `gry_par`=0.
- Back-to-back `bin_valid` held high with 16 sequential values 0..15, `gry_ready`=1:
  - Each result equals bin^(bin>>1).
  - Adjacent results differ in exactly one bit.
  - Spacing is 6 cycles per word.

Source files
------------

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the binary<->Gray serial codec stages.
//   GRAY_W       : default code width, common to encoder and decoder
//   gray_state_t : three-state handshake FSM encoding (IDLE / CALC / HOLD)
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } gray_state_t;

endpackage : gray_pkg

// File: rtl/bin2gry_ser.sv
// -----------------------------------------------------------------------------
// bin2gry_ser
// Bit-serial binary-to-Gray encoder with valid/ready handshakes on both sides.
// One Gray bit is produced per clock, MSB first. The finished word is held on
// registered outputs until the downstream stage accepts it.
//
// Parameters:
//   WIDTH      : code width in bits (>= 2), default gray_pkg::GRAY_W
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bin_in     : binary word, sampled on input handshake
//   bin_valid  : upstream word valid
//   bin_ready  : block can accept a word (registered, IDLE only)
//   gry_out    : Gray result, registered, kept until the next result
//   gry_valid  : gry_out valid (HOLD)
//   gry_ready  : downstream accepts result
//   busy       : high in CALC or HOLD
//   gry_par    : XOR of all gry_out bits (only with B2G_PARITY_EN)
//
// Build option:
//   B2G_PARITY_EN : adds the gry_par output, registered with gry_out.
// -----------------------------------------------------------------------------
import gray_pkg::*;

module bin2gry_ser #(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [WIDTH-1:0] gry_out,
  output logic             gry_valid,
  input  logic             gry_ready,
`ifdef B2G_PARITY_EN
  output logic             gry_par,
`endif
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

`ifdef B2G_PARITY_EN
  // Even-parity helper over one code word.
  function automatic logic word_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  gray_state_t      state;
  gray_state_t      state_nx;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gry_q;
  logic [WIDTH-1:0] gry_full;
  logic [WIDTH-1:0] gry_step;
  logic [WIDTH-1:0] gry_out_q;
  logic             valid_q;
  logic             ready_q;
  logic [IW-1:0]    idx;
  logic             load_in;
  logic             load_out;
  logic             step_calc;
`ifdef B2G_PARITY_EN
  logic             par_q;
`endif

  // bin_q >> 1 shifts in the zero MSB neighbour, so the MSB is copied as-is.
  assign gry_full = bin_q ^ (bin_q >> 1);

  // Partial result with the bit at the current index filled in.
  always_comb begin
    gry_step      = gry_q;
    gry_step[idx] = gry_full[idx];
  end

  // Next-state and control decode for the handshake FSM.
  always_comb begin
    state_nx  = state;
    load_in   = 1'b0;
    load_out  = 1'b0;
    step_calc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bin_valid && ready_q) begin
          state_nx = ST_CALC;
          load_in  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_calc = 1'b1;
        if (idx == IDX_ZERO) begin
          state_nx = ST_HOLD;
          load_out = 1'b1;
        end else begin
          state_nx = ST_CALC;
        end
      end
      ST_HOLD: begin
        if (valid_q && gry_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Input capture, serial accumulation and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= {WIDTH{1'b0}};
      gry_q <= {WIDTH{1'b0}};
      idx   <= IDX_ZERO;
    end else if (load_in) begin
      bin_q <= bin_in;
      idx   <= IDX_MSB;
    end else if (step_calc) begin
      gry_q <= gry_step;
      if (idx != IDX_ZERO) begin
        idx <= idx - IDX_ONE;
      end
    end
  end

  // Registered outputs; gry_out is only rewritten when a new word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gry_out_q <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (state_nx == ST_IDLE);
      if (load_out) begin
        gry_out_q <= gry_step;
        valid_q   <= 1'b1;
      end else if (state_nx == ST_IDLE) begin
        valid_q   <= 1'b0;
      end
    end
  end

`ifdef B2G_PARITY_EN
  // Parity captured together with gry_out so the pair is always consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load_out) begin
      par_q <= word_parity(gry_step);
    end
  end

  assign gry_par = par_q;
`endif

  assign bin_ready = ready_q;
  assign gry_out   = gry_out_q;
  assign gry_valid = valid_q;
  assign busy      = (state == ST_CALC) || (state == ST_HOLD);

endmodule : bin2gry_ser
